cfu_pipe_arbiter: RTL and testbench

- Round-robin arbiter that shares one Level-1 (fixed-latency, II=1, no req_ready/resp_ready) pipelined CFU, such as the multiply-accumulate CFU, among N_REQ requesters.
- Gives each requester a valid/ready request handshake.
- Tracks the owner of every in-flight request in a latency-matched shadow pipeline, and steers each response back to the requester that issued it.
- Sits between the core-side CFU request muxes and a single shared CFU instance.

---
 rtl/cfu_pipe_arbiter_if.sv | 45 ++++
 rtl/cfu_pipe_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_cfu_pipe_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cfu_pipe_arbiter_if.sv
// Requester-side and shared-CFU-side signal bundle for cfu_pipe_arbiter.
// slave = arbiter view, master = environment (requesters + CFU) view.
interface cfu_pipe_arbiter_if #(
  parameter int N_REQ             = 4,
  parameter int CFU_FUNCTION_ID_W = 16,
  parameter int CFU_REQ_RESP_ID_W = 6,
  parameter int CFU_REQ_DATA_W    = 32,
  parameter int CFU_RESP_DATA_W   = CFU_REQ_DATA_W,
  parameter int CFU_ERROR_ID_W    = CFU_RESP_DATA_W
);
  logic [N_REQ-1:0]                     req_valid;
  logic [N_REQ-1:0]                     req_ready;
  logic [N_REQ*CFU_FUNCTION_ID_W-1:0]   req_function_id;
  logic [N_REQ*CFU_REQ_RESP_ID_W-1:0]   req_id;
  logic [N_REQ*2*CFU_REQ_DATA_W-1:0]    req_data;
  logic [N_REQ-1:0]                     req_lock;
  logic [N_REQ-1:0]                     resp_valid;
  logic [CFU_REQ_RESP_ID_W-1:0]         resp_id;
  logic [CFU_RESP_DATA_W-1:0]           resp_data;
  logic                                 resp_ok;
  logic [CFU_ERROR_ID_W-1:0]            resp_error_id;
  logic                                 cfu_req_valid;
  logic [CFU_FUNCTION_ID_W-1:0]         cfu_req_function_id;
  logic [CFU_REQ_RESP_ID_W-1:0]         cfu_req_id;
  logic [2*CFU_REQ_DATA_W-1:0]          cfu_req_data;
  logic                                 cfu_resp_valid;
  logic [CFU_REQ_RESP_ID_W-1:0]         cfu_resp_id;
  logic [CFU_RESP_DATA_W-1:0]           cfu_resp_data;
  logic                                 cfu_resp_ok;
  logic [CFU_ERROR_ID_W-1:0]            cfu_resp_error_id;

  modport slave (
    input  req_valid, req_function_id, req_id, req_data, req_lock,
    input  cfu_resp_valid, cfu_resp_id, cfu_resp_data, cfu_resp_ok, cfu_resp_error_id,
    output req_ready, resp_valid, resp_id, resp_data, resp_ok, resp_error_id,
    output cfu_req_valid, cfu_req_function_id, cfu_req_id, cfu_req_data
  );

  modport master (
    output req_valid, req_function_id, req_id, req_data, req_lock,
    output cfu_resp_valid, cfu_resp_id, cfu_resp_data, cfu_resp_ok, cfu_resp_error_id,
    input  req_ready, resp_valid, resp_id, resp_data, resp_ok, resp_error_id,
    input  cfu_req_valid, cfu_req_function_id, cfu_req_id, cfu_req_data
  );
endinterface

// File: rtl/cfu_pipe_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined CFU among N_REQ requesters,
// with a latency-matched owner pipeline for response steering. Grant lock: CFU_ARB_LOCK_EN.
module cfu_pipe_arbiter #(
  parameter int N_REQ             = 4,
  parameter int CFU_FUNCTION_ID_W = 16,
  parameter int CFU_REQ_RESP_ID_W = 6,
  parameter int CFU_REQ_DATA_W    = 32,
  parameter int CFU_RESP_DATA_W   = CFU_REQ_DATA_W,
  parameter int CFU_ERROR_ID_W    = CFU_RESP_DATA_W,
  parameter int CFU_LATENCY       = 3
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clock_en,
  cfu_pipe_arbiter_if.slave        bus,
  output logic                     err_seq
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int FW    = CFU_FUNCTION_ID_W;
  localparam int IW    = CFU_REQ_RESP_ID_W;
  localparam int DW2   = 2 * CFU_REQ_DATA_W;

  // Returns {found, idx} of the first eligible requester at or after ptr, wrapping.
  function automatic logic [IDX_W:0] rr_pick(input logic [IDX_W-1:0] ptr,
                                             input logic [N_REQ-1:0] vld);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] cand;
    res = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'((32'(ptr) + 32'(k)) % N_REQ);
      if (vld[cand]) res = {1'b1, cand};
    end
    return res;
  endfunction

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0] elig_s;
  logic [IDX_W:0]   pick_s;
  logic             grant_s;
  logic [IDX_W-1:0] win_s;
  logic             sh_v_q   [CFU_LATENCY];
  logic             sh_v_d   [CFU_LATENCY];
  logic [IDX_W-1:0] sh_idx_q [CFU_LATENCY];
  logic [IDX_W-1:0] sh_idx_d [CFU_LATENCY];
  logic [IW-1:0]    sh_id_q  [CFU_LATENCY];
  logic [IW-1:0]    sh_id_d  [CFU_LATENCY];
  logic             tail_v_s;
  logic [IDX_W-1:0] tail_idx_s;
  logic [IW-1:0]    tail_id_s;
  logic             err_q, err_d;

`ifdef CFU_ARB_LOCK_EN
  logic             locked_q, locked_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;

  // A held lock masks every requester except the lock owner.
  always_comb begin
    elig_s = '0;
    if (locked_q) begin
      elig_s[lock_idx_q] = bus.req_valid[lock_idx_q];
    end else begin
      elig_s = bus.req_valid;
    end
  end

  // Lock acquire/release on accepted requests.
  always_comb begin
    locked_d   = locked_q;
    lock_idx_d = lock_idx_q;
    if (grant_s) begin
      if (locked_q) begin
        locked_d = bus.req_lock[win_s];
      end else if (bus.req_lock[win_s]) begin
        locked_d   = 1'b1;
        lock_idx_d = win_s;
      end else begin
        locked_d = 1'b0;
      end
    end else begin
      locked_d = locked_q;
    end
  end

  // Lock state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      locked_q   <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      locked_q   <= locked_d;
      lock_idx_q <= lock_idx_d;
    end
  end
`else
  logic unused_lock_s;
  assign unused_lock_s = ^bus.req_lock;
  assign elig_s        = bus.req_valid;
`endif

  // Winner selection and zero-latency issue mux; nothing is granted while in reset.
  always_comb begin
    pick_s                  = rr_pick(rr_ptr_q, elig_s);
    grant_s                 = reset & clock_en & pick_s[IDX_W];
    win_s                   = pick_s[IDX_W-1:0];
    bus.req_ready           = '0;
    bus.cfu_req_valid       = grant_s;
    bus.cfu_req_function_id = '0;
    bus.cfu_req_id          = '0;
    bus.cfu_req_data        = '0;
    if (grant_s) begin
      bus.req_ready[win_s]    = 1'b1;
      bus.cfu_req_function_id = bus.req_function_id[win_s*FW +: FW];
      bus.cfu_req_id          = bus.req_id[win_s*IW +: IW];
      bus.cfu_req_data        = bus.req_data[win_s*DW2 +: DW2];
    end else begin
      bus.req_ready = '0;
    end
  end

  // Pointer moves one past the winner on acceptance.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_s) begin
      rr_ptr_d = (win_s == IDX_W'(N_REQ - 1)) ? '0 : win_s + 1'b1;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Owner pipeline advances in lockstep with the CFU.
  always_comb begin
    sh_v_d   = sh_v_q;
    sh_idx_d = sh_idx_q;
    sh_id_d  = sh_id_q;
    if (clock_en) begin
      sh_v_d[0]   = grant_s;
      sh_idx_d[0] = win_s;
      sh_id_d[0]  = bus.cfu_req_id;
      for (int k = 1; k < CFU_LATENCY; k++) begin
        sh_v_d[k]   = sh_v_q[k-1];
        sh_idx_d[k] = sh_idx_q[k-1];
        sh_id_d[k]  = sh_id_q[k-1];
      end
    end else begin
      sh_v_d = sh_v_q;
    end
  end

  // Response steering and sequencing check against the pipeline tail.
  always_comb begin
    tail_v_s       = sh_v_q[CFU_LATENCY-1];
    tail_idx_s     = sh_idx_q[CFU_LATENCY-1];
    tail_id_s      = sh_id_q[CFU_LATENCY-1];
    bus.resp_valid = '0;
    for (int i = 0; i < N_REQ; i++) begin
      bus.resp_valid[i] = bus.cfu_resp_valid & tail_v_s & (tail_idx_s == IDX_W'(i));
    end
    err_d = err_q;
    if (clock_en && ((bus.cfu_resp_valid != tail_v_s) ||
                     (bus.cfu_resp_valid && (bus.cfu_resp_id != tail_id_s)))) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  assign bus.resp_id       = bus.cfu_resp_id;
  assign bus.resp_data     = bus.cfu_resp_data;
  assign bus.resp_ok       = bus.cfu_resp_ok;
  assign bus.resp_error_id = bus.cfu_resp_error_id;
  assign err_seq           = err_q;

  // State registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr_q <= '0;
      sh_v_q   <= '{default: 1'b0};
      sh_idx_q <= '{default: '0};
      sh_id_q  <= '{default: '0};
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      sh_v_q   <= sh_v_d;
      sh_idx_q <= sh_idx_d;
      sh_id_q  <= sh_id_d;
      err_q    <= err_d;
    end
  end
endmodule

// File: tb/tb_cfu_pipe_arbiter.sv
// Randomised self-checking bench for cfu_pipe_arbiter: a small sum CFU plus a
// history-based reference model of grants, owners and sequencing errors.
module tb_cfu_pipe_arbiter;
  localparam int N  = 4;
  localparam int FW = 16;
  localparam int IW = 6;
  localparam int DW = 32;
  localparam int L  = 3;
  localparam int HN = 1024;
`ifdef CFU_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clock;
  logic reset;
  logic clock_en;
  logic err_seq;
  logic inj_valid;
  logic inj_id;

  cfu_pipe_arbiter_if bus ();

  cfu_pipe_arbiter dut (
    .clock    (clock),
    .reset    (reset),
    .clock_en (clock_en),
    .bus      (bus),
    .err_seq  (err_seq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Shared CFU stand-in: fixed latency L, result = op0 + op1.
  logic          cv_q [L];
  logic [IW-1:0] cid_q [L];
  logic [DW-1:0] cdat_q [L];
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < L; k++) begin
        cv_q[k]   <= 1'b0;
        cid_q[k]  <= '0;
        cdat_q[k] <= '0;
      end
    end else if (clock_en) begin
      cv_q[0]   <= bus.cfu_req_valid;
      cid_q[0]  <= bus.cfu_req_id;
      cdat_q[0] <= bus.cfu_req_data[DW-1:0] + bus.cfu_req_data[2*DW-1:DW];
      for (int k = 1; k < L; k++) begin
        cv_q[k]   <= cv_q[k-1];
        cid_q[k]  <= cid_q[k-1];
        cdat_q[k] <= cdat_q[k-1];
      end
    end
  end
  assign bus.cfu_resp_valid    = inj_valid | cv_q[L-1];
  assign bus.cfu_resp_id       = cid_q[L-1] ^ {{(IW-1){1'b0}}, inj_id};
  assign bus.cfu_resp_data     = cdat_q[L-1];
  assign bus.cfu_resp_ok       = cv_q[L-1];
  assign bus.cfu_resp_error_id = ~cdat_q[L-1];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int            m_ptr;
  int            m_ce;
  bit            m_err;
  bit            m_locked;
  int            m_lock_idx;
  int            h_owner [HN];
  logic [IW-1:0] h_id [HN];

  logic [N-1:0]  obs_ready;
  logic [N-1:0]  obs_resp_valid;
  logic [IW-1:0] obs_resp_id;
  logic          obs_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    m_ptr = 0; m_ce = 0; m_err = 1'b0; m_locked = 1'b0; m_lock_idx = 0;
  endtask

  task automatic rand_fields();
    for (int i = 0; i < N; i++) begin
      bus.req_function_id[i*FW +: FW] = 16'($urandom);
      bus.req_id[i*IW +: IW]          = 6'($urandom);
      bus.req_data[i*2*DW +: 2*DW]    = {32'($urandom), 32'($urandom)};
    end
  endtask

  // One cycle: drive after the falling edge, compare to the model, advance the model.
  task automatic step(input logic ce, input logic [N-1:0] v, input logic [N-1:0] lk);
    int win, w, st, towner;
    logic tv;
    logic [IW-1:0] tid;
    clock_en      = ce;
    bus.req_valid = v;
    bus.req_lock  = lk;
    #1;
    win = -1;
    if (reset && ce) begin
      if (LOCK_EN && m_locked) begin
        if (v[m_lock_idx]) win = m_lock_idx;
      end else begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_ptr + k) % N;
          if (v[j] && win < 0) win = j;
        end
      end
    end
    w = (win < 0) ? 0 : win;
    st = m_ce - L;
    tv = 1'b0; towner = 0; tid = '0;
    if (reset && st >= 0 && h_owner[st % HN] >= 0) begin
      tv = 1'b1; towner = h_owner[st % HN]; tid = h_id[st % HN];
    end
    obs_ready      = bus.req_ready;
    obs_resp_valid = bus.resp_valid;
    obs_resp_id    = bus.resp_id;
    obs_err        = err_seq;
    chk("req_ready", bus.req_ready, (win >= 0) ? (64'd1 << win) : 64'd0);
    chk("cfu_req_valid", bus.cfu_req_valid, (win >= 0) ? 64'd1 : 64'd0);
    chk("cfu_req_function_id", bus.cfu_req_function_id,
        (win >= 0) ? 64'(bus.req_function_id[w*FW +: FW]) : 64'd0);
    chk("cfu_req_id", bus.cfu_req_id, (win >= 0) ? 64'(bus.req_id[w*IW +: IW]) : 64'd0);
    chk("cfu_req_data", bus.cfu_req_data,
        (win >= 0) ? 64'(bus.req_data[w*2*DW +: 2*DW]) : 64'd0);
    chk("resp_valid", bus.resp_valid,
        (bus.cfu_resp_valid && tv) ? (64'd1 << towner) : 64'd0);
    chk("resp_id", bus.resp_id, bus.cfu_resp_id);
    chk("resp_data", bus.resp_data, bus.cfu_resp_data);
    chk("resp_ok", bus.resp_ok, bus.cfu_resp_ok);
    chk("resp_error_id", bus.resp_error_id, bus.cfu_resp_error_id);
    chk("err_seq", err_seq, m_err);
    if (reset && ce) begin
      if ((bus.cfu_resp_valid != tv) || (bus.cfu_resp_valid && (bus.cfu_resp_id != tid)))
        m_err = 1'b1;
      h_owner[m_ce % HN] = win;
      h_id[m_ce % HN]    = (win >= 0) ? bus.req_id[w*IW +: IW] : '0;
      m_ce++;
      if (win >= 0) begin
        m_ptr = (win + 1) % N;
        if (LOCK_EN) begin
          if (m_locked) begin
            if (!lk[win]) m_locked = 1'b0;
          end else if (lk[win]) begin
            m_locked = 1'b1; m_lock_idx = win;
          end
        end
      end
    end
    @(negedge clock);
  endtask

  // Asynchronous reset between clock edges; outputs must drop at once.
  task automatic do_reset();
    #2;
    reset = 1'b0;
    #1;
    chk("rst_req_ready", bus.req_ready, 64'd0);
    chk("rst_cfu_req_valid", bus.cfu_req_valid, 64'd0);
    chk("rst_cfu_req_id", bus.cfu_req_id, 64'd0);
    chk("rst_resp_valid", bus.resp_valid, 64'd0);
    chk("rst_err_seq", err_seq, 64'd0);
    reset_model();
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; clock_en = 1'b1; inj_valid = 1'b0; inj_id = 1'b0;
    bus.req_valid = '1; bus.req_lock = '0;
    bus.req_function_id = '0; bus.req_id = '0; bus.req_data = '0;
    reset_model();
    #12;
    chk("init_req_ready", bus.req_ready, 64'd0);
    chk("init_cfu_req_valid", bus.cfu_req_valid, 64'd0);
    chk("init_resp_valid", bus.resp_valid, 64'd0);
    chk("init_err_seq", err_seq, 64'd0);
    @(negedge clock);
    reset = 1'b1;

    // Single requester, response 3 cycles later
    rand_fields();
    bus.req_id[2*IW +: IW] = 6'd5;
    step(1'b1, 4'b0100, 4'b0000);
    chk("single_ready", obs_ready, 64'h4);
    for (int k = 0; k < 3; k++) begin rand_fields(); step(1'b1, 4'b0000, 4'b0000); end
    chk("single_resp_valid", obs_resp_valid, 64'h4);
    chk("single_resp_id", obs_resp_id, 64'd5);
    chk("single_err", obs_err, 64'd0);

    // All requesters valid from rr_ptr=0
    rand_fields(); step(1'b1, 4'b1000, 4'b0000);
    for (int k = 0; k < 8; k++) begin
      rand_fields();
      step(1'b1, 4'b1111, 4'b0000);
      chk("rr_ready", obs_ready, 64'd1 << (k % 4));
      if (k >= 3) chk("rr_resp_valid", obs_resp_valid, 64'd1 << ((k - 3) % 4));
    end

    // Fairness wrap from rr_ptr=2 with requesters 3 and 1
    rand_fields(); step(1'b1, 4'b0010, 4'b0000);
    rand_fields(); step(1'b1, 4'b1010, 4'b0000); chk("wrap_a", obs_ready, 64'h8);
    rand_fields(); step(1'b1, 4'b1010, 4'b0000); chk("wrap_b", obs_ready, 64'h2);
    rand_fields(); step(1'b1, 4'b1010, 4'b0000); chk("wrap_c", obs_ready, 64'h8);

    // clock_en stall mid-stream
    rand_fields(); step(1'b1, 4'b1111, 4'b0000); chk("stall_pre", obs_ready, 64'h1);
    rand_fields(); step(1'b0, 4'b1111, 4'b0000); chk("stall_0", obs_ready, 64'h0);
    rand_fields(); step(1'b0, 4'b1111, 4'b0000); chk("stall_1", obs_ready, 64'h0);
    rand_fields(); step(1'b1, 4'b1111, 4'b0000); chk("stall_post", obs_ready, 64'h2);

    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      rand_fields();
      step(($urandom_range(0, 9) != 0), 4'($urandom),
           ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000);
    end
    do_reset();

    // Orphan response: no owner, not delivered, sticky error
    for (int k = 0; k < 4; k++) begin rand_fields(); step(1'b1, 4'b0000, 4'b0000); end
    inj_valid = 1'b1;
    step(1'b1, 4'b0000, 4'b0000);
    chk("orphan_resp_valid", obs_resp_valid, 64'h0);
    inj_valid = 1'b0;
    step(1'b1, 4'b0000, 4'b0000);
    chk("orphan_err", obs_err, 64'd1);
    for (int k = 0; k < 4; k++) begin rand_fields(); step(1'b1, 4'b1111, 4'b0000); end
    chk("orphan_err_sticky", obs_err, 64'd1);
    do_reset();

    // Response id mismatch
    rand_fields(); step(1'b1, 4'b0001, 4'b0000);
    for (int k = 0; k < 2; k++) begin rand_fields(); step(1'b1, 4'b0000, 4'b0000); end
    inj_id = 1'b1;
    step(1'b1, 4'b0000, 4'b0000);
    chk("idfault_err_before", obs_err, 64'd0);
    inj_id = 1'b0;
    step(1'b1, 4'b0000, 4'b0000);
    chk("idfault_err_after", obs_err, 64'd1);
    do_reset();

`ifdef CFU_ARB_LOCK_EN
    // Requester 1 holds the CFU across a locked sequence while requester 0 waits
    rand_fields(); step(1'b1, 4'b0010, 4'b0010); chk("lock_a", obs_ready, 64'h2);
    rand_fields(); step(1'b1, 4'b0011, 4'b0010); chk("lock_b", obs_ready, 64'h2);
    rand_fields(); step(1'b1, 4'b0011, 4'b0010); chk("lock_c", obs_ready, 64'h2);
    rand_fields(); step(1'b1, 4'b0011, 4'b0000); chk("lock_d", obs_ready, 64'h2);
    rand_fields(); step(1'b1, 4'b0011, 4'b0000); chk("lock_e", obs_ready, 64'h1);
`endif
    for (int k = 0; k < 4; k++) begin rand_fields(); step(1'b1, 4'b0000, 4'b0000); end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
